// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple chain of
// full adders, carry registered between digits, with add/sub/accumulate modes.
module digit_serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic [1:0]       dbg_state_o
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   opa_q;
   logic [WIDTH-1:0]   opb_q;
   logic [WIDTH-1:0]   res_q;
   logic               carry_q;
   logic [CW-1:0]      cnt_q;
   logic               sign_a_q;
   logic               sign_b_q;

   logic               accept;
   logic               last_digit;
   logic [WIDTH-1:0]   sel_a;
   logic [WIDTH-1:0]   sel_b;
   logic               sel_c;
   logic [DIGIT-1:0]   dig_sum;
   logic               dig_carry;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic [WIDTH-1:0]   res_d;

   // Subtraction is A + ~B + 1, so the operand is inverted once at accept time.
   assign accept     = start && (state_q != S_RUN);
   assign last_digit = (cnt_q == CW'(NDIG - 1));
   assign sel_a      = op[1] ? sum : a;
   assign sel_b      = op[0] ? ~b : b;
   assign sel_c      = op[0] | c_in;
   assign dbg_state_o = state_q;

   always_comb begin
      dig_carry = carry_q;
      dig_sum   = '0;
      for (int i = 0; i < DIGIT; i++) begin
         dig_sum[i] = opa_q[i] ^ opb_q[i] ^ dig_carry;
         dig_carry  = (opa_q[i] & opb_q[i]) | (dig_carry & (opa_q[i] ^ opb_q[i]));
      end
   end

   // New digit enters at the top; after NDIG shifts the last digit sits in the MSBs.
   assign res_cat = {dig_sum, res_q};
   assign res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: ;
            S_RUN: begin
               opa_q   <= opa_q >> DIGIT;
               opb_q   <= opb_q >> DIGIT;
               res_q   <= res_d;
               carry_q <= dig_carry;
               cnt_q   <= cnt_q + CW'(1);
               if (last_digit) begin
                  state_q  <= S_DONE;
                  cnt_q    <= '0;
                  sum      <= res_d;
                  c_out    <= dig_carry;
                  overflow <= (sign_a_q == sign_b_q) && (res_d[WIDTH-1] != sign_a_q);
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         if (accept) begin
            state_q  <= S_RUN;
            busy     <= 1'b1;
            opa_q    <= sel_a;
            opb_q    <= sel_b;
            carry_q  <= sel_c;
            sign_a_q <= sel_a[WIDTH-1];
            sign_b_q <= sel_b[WIDTH-1];
            res_q    <= '0;
            cnt_q    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Random and directed checks of digit_serial_adder in four WIDTH/DIGIT configurations,
// scored against a signed/unsigned arithmetic model of the add/sub/accumulate ops.
module tb_digit_serial_adder;

   localparam int PER  = 10;
   localparam int HALF = 5;

   logic clk = 1'b0;
   always #HALF clk = ~clk;

   int total = 0;
   int bad = 0;
   int fin_cnt = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : cfg
      localparam int W = (g == 3) ? 16 : 8;
      localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 8 : 4;
      localparam int N = W / D;

      logic         rst;
      logic         start_s;
      logic [1:0]   op_s;
      logic [W-1:0] a_s;
      logic [W-1:0] b_s;
      logic         cin_s;
      logic [W-1:0] sum;
      logic         c_out;
      logic         ovf;
      logic         busy;
      logic         done;
      logic [1:0]   dbg_state;

      digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
         .clk(clk), .reset(rst), .start(start_s), .op(op_s), .a(a_s), .b(b_s),
         .c_in(cin_s), .sum(sum), .c_out(c_out), .overflow(ovf), .busy(busy),
         .done(done), .dbg_state_o(dbg_state)
      );

      logic [W+1:0] exp_q[$];
      time          t_q[$];
      logic [W-1:0] model_r = '0;
      int           done_cnt = 0;

      function automatic string nm(input string s);
         return $sformatf("w%0d_d%0d_%s", W, D, s);
      endfunction

      // Returns {c_out, overflow, sum} from plain integer arithmetic.
      function automatic logic [W+1:0] model(input logic [1:0] op, input logic [W-1:0] av,
                                             input logic [W-1:0] bv, input logic ci,
                                             input logic [W-1:0] r);
         longint ua, ub, sa, sb, us, ss, lim;
         logic c, ov;
         logic [W-1:0] s;
         lim = longint'(1) << W;
         ua = op[1] ? longint'(r) : longint'(av);
         ub = longint'(bv);
         sa = (ua >= lim / 2) ? ua - lim : ua;
         sb = (ub >= lim / 2) ? ub - lim : ub;
         if (op[0]) begin
            us = ua - ub;
            ss = sa - sb;
            c  = (ua >= ub);
         end else begin
            us = ua + ub + longint'(ci);
            ss = sa + sb + longint'(ci);
            c  = (us >= lim);
         end
         ov = (ss > lim / 2 - 1) || (ss < -(lim / 2));
         s  = us[W-1:0];
         return {c, ov, s};
      endfunction

      task automatic issue(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic ci, input bit mid_change);
         int guard;
         logic [W+1:0] e;
         guard = 0;
         @(negedge clk);
         while (busy && guard < 4 * N + 10) begin
            @(negedge clk);
            guard++;
         end
         if (busy) check(nm("idle_wait"), busy, 0);
         op_s = op; a_s = av; b_s = bv; cin_s = ci; start_s = 1'b1;
         e = model(op, av, bv, ci, model_r);
         model_r = e[W-1:0];
         @(posedge clk);
         exp_q.push_back(e);
         t_q.push_back($time);
         #1;
         start_s = 1'b0;
         op_s = 2'($urandom()); a_s = W'($urandom()); b_s = W'($urandom()); cin_s = ~ci;
         if (mid_change) begin
            @(negedge clk);
            start_s = 1'b1;
            a_s = W'($urandom()); b_s = W'($urandom()); op_s = 2'($urandom());
            @(posedge clk);
            #1 start_s = 1'b0;
         end
      endtask

      task automatic check_reset_outputs(input string tag);
         check(nm({tag, "_sum"}), sum, 0);
         check(nm({tag, "_cout"}), c_out, 0);
         check(nm({tag, "_ovf"}), ovf, 0);
         check(nm({tag, "_busy"}), busy, 0);
         check(nm({tag, "_done"}), done, 0);
         check(nm({tag, "_state"}), dbg_state, 0);
      endtask

      task automatic mid_run_reset();
         int snap;
         int guard;
         guard = 0;
         @(negedge clk);
         while (busy && guard < 4 * N + 10) begin
            @(negedge clk);
            guard++;
         end
         op_s = 2'd0; a_s = W'($urandom()); b_s = W'($urandom()); cin_s = 1'b1; start_s = 1'b1;
         @(posedge clk);
         #1 start_s = 1'b0;
         @(negedge clk);
         rst = 1'b1;
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         model_r = '0;
         check_reset_outputs("midrst");
         snap = done_cnt;
         repeat (N + 3) @(negedge clk);
         check(nm("midrst_no_done"), done_cnt - snap, 0);
      endtask

      initial begin
         int guard;
         rst = 1'b1; start_s = 1'b0; op_s = '0; a_s = '0; b_s = '0; cin_s = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         check_reset_outputs("rst");

         issue(2'd0, W'(8'h5A), W'(8'h3C), 1'b0, 1'b0);
         issue(2'd2, W'(8'h00), W'(8'h70), 1'b0, 1'b0);
         issue(2'd3, W'(8'h00), W'(8'h07), 1'b0, 1'b0);
         issue(2'd0, W'(8'hFF), W'(8'h01), 1'b1, 1'b0);
         issue(2'd1, W'(8'h10), W'(8'h20), 1'b1, 1'b0);
         issue(2'd0, W'(8'h33), W'(8'h44), 1'b0, 1'b1);
         issue(2'd1, W'(8'h80), W'(8'h01), 1'b0, 1'b0);
         issue(2'd0, {1'b0, {(W-1){1'b1}}}, '0, 1'b1, 1'b0);
         mid_run_reset();

         repeat (1000) begin
            issue(2'($urandom_range(0, 3)), W'($urandom()), W'($urandom()),
                  1'($urandom()), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3) * N) @(negedge clk);
         end

         guard = 0;
         while (exp_q.size() != 0 && guard < 4 * N + 20) begin
            @(negedge clk);
            guard++;
         end
         check(nm("drain"), exp_q.size(), 0);
         fin_cnt++;
      end

      int run_len = 0;
      bit prev_done = 1'b0;
      always @(negedge clk) begin
         logic [W+1:0] e;
         time t;
         if (rst) begin
            run_len = 0;
            prev_done = 1'b0;
         end else begin
            if (busy) run_len++;
            else if (run_len != 0) begin
               check(nm("busy_len"), run_len, N);
               run_len = 0;
            end
            if (done) begin
               done_cnt++;
               check(nm("done_busy"), busy, 0);
               check(nm("done_width"), prev_done, 0);
               check(nm("done_expected"), longint'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  t = t_q.pop_front();
                  check(nm("sum"), sum, e[W-1:0]);
                  check(nm("c_out"), c_out, e[W+1]);
                  check(nm("overflow"), ovf, e[W]);
                  check(nm("latency"), longint'(($time - t + HALF) / PER), N + 1);
               end
            end
            prev_done = done;
         end
      end
   end

   initial begin
      int cyc;
      cyc = 0;
      while (fin_cnt < 4 && cyc < 90000) begin
         @(posedge clk);
         cyc++;
      end
      if (fin_cnt < 4) begin
         total++;
         bad++;
         $display("FAIL global_timeout: finished %0d of 4 configs", fin_cnt);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle successor to the combinational 4-bit ripple adder.
- Processes DIGIT bits per clock through a DIGIT-wide ripple chain of full adders, with a registered carry between digits.
- Adds add/subtract/accumulate modes, a start/done handshake and signed-overflow detection.
- Used where wide adds must trade latency for area, e.g. datapath labs driving HEX/LEDR displays.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 2, bits processed per cycle, 1..WIDTH; NDIG = WIDTH/DIGIT is the number of RUN cycles.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled only when not busy.
op  input  2  00 add A+B+c_in; 01 sub A-B; 10 acc-add R+B+c_in; 11 acc-sub R-B.
a  input  WIDTH  operand A; ignored for op 10/11.
b  input  WIDTH  operand B.
c_in  input  1  carry in for op 00/10; ignored for subtract ops.
sum  output  WIDTH  registered result R; held until the next completion.
c_out  output  1  carry out of MSB (subtract: 1 = no borrow).
overflow  output  1  two's-complement overflow of the last result.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when sum/c_out/overflow update.

Behaviour:
- Reset (synchronous, any state): state IDLE; sum=0, c_out=0, overflow=0, busy=0, done=0. Internal shift registers, digit counter and carry register are cleared. Reset mid-RUN aborts the operation; no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> RUN while digit count < NDIG-1; RUN -> DONE after the last digit.
  - DONE -> RUN if start=1, else DONE -> IDLE.
- Start acceptance: start is accepted in IDLE and DONE. It is ignored in RUN; op/a/b/c_in changes during RUN have no effect.
- On accept, latch into internal registers:
  - opA = a for op 00/01; opA = current sum (R) for op 10/11.
  - opB = b for add ops; opB = ~b for subtract ops.
  - carry = c_in for add ops; carry = 1 for subtract ops.
  - Record the sign bits of opA and opB.
- Each RUN cycle:
  - Add the low DIGIT bits of opA, opB and carry.
  - Shift opA/opB right by DIGIT.
  - Shift the DIGIT result bits into the top of a result shift register; the last digit ends up as the MSBs.
  - Store the digit carry-out in the carry register.
- Completion, on the edge leaving the final RUN cycle:
  - sum <= full result; c_out <= final carry.
  - overflow <= (signA == signB_eff) && (sum MSB != signA).
  - done=1 for exactly the DONE cycle.
- Latency: start sampled at edge k -> done high in the cycle after edge k+NDIG. Back-to-back starts in DONE give one result every NDIG+1 cycles.
- busy=1 exactly in RUN; done and busy are never high together.
- Arithmetic is modulo 2^WIDTH. sum, c_out and overflow change only at completion or reset.
- Accumulate ops read R as it was at the accept edge, so a start in the DONE cycle sees the just-completed result.

Test Plan:
(WIDTH=8, DIGIT=2 unless noted)
1. Reset: assert reset for 2 cycles, including once mid-RUN -> sum=0x00, c_out=0, overflow=0, busy=0, done=0; no done pulse follows the aborted run.
2. Add: op=00, a=0x5A, b=0x3C, c_in=0, start pulse -> busy high 4 cycles, then done 1 cycle; sum=0x96, c_out=0, overflow=1.
3. Carry chain: op=00, a=0xFF, b=0x01, c_in=1 -> sum=0x01, c_out=1, overflow=0. Subtract: op=01, a=0x10, b=0x20, c_in=1 -> sum=0xF0, c_out=0, overflow=0.
4. Accumulate: after test 2 (R=0x96), op=10, b=0x70, c_in=0, start asserted in the DONE cycle -> sum=0x06, c_out=1, overflow=0. Then op=11, b=0x07 -> sum=0xFF, c_out=0, overflow=0.
5. Handshake: pulse start again while busy, changing a/b mid-RUN -> ignored; result equals the originally latched operands; exactly one done pulse.
6. Parameter sweep: DIGIT=1 and DIGIT=8 with WIDTH=8, and WIDTH=16/DIGIT=4. Run 1000 random ops against a reference model -> results match; done arrives exactly NDIG+1 cycles after the start edge (9, 2 and 5 respectively).
